reg_writeback: RTL and testbench
================================

Name: reg_writeback

Overview:
Write-side front end of the dual-issue register file. Collects results from the master pipe, the slave pipe and an asynchronous long-latency source (load miss, mul/div) and drives the file's two write ports: port 1 = wen1_a/waddr1_a/wdata1_a, port 2 = wen2_a/waddr2_a/wdata2_a. In-order pipe results always win a port. Long-latency results wait in a small FIFO until a port is idle. WAW collisions are resolved so that the youngest value always lands last.

Parameters:
DEPTH, 4, async result FIFO entries (power of two, 2..8)
AW, 5, register address width
DW, 32, data width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
m_valid  in  1  master pipe writes this cycle
m_waddr  in  AW  master destination
m_wdata  in  DW  master result
s_valid  in  1  slave pipe writes this cycle (slave is younger than master)
s_waddr  in  AW  slave destination
s_wdata  in  DW  slave result
a_valid  in  1  async result offered
a_ready  out  1  FIFO can accept
a_waddr  in  AW  async destination
a_wdata  in  DW  async result
wen1_a  out  1  port 1 write enable
waddr1_a  out  AW  port 1 address
wdata1_a  out  DW  port 1 data
wen2_a  out  1  port 2 write enable
waddr2_a  out  AW  port 2 address
wdata2_a  out  DW  port 2 data

Behaviour:
- Reset: all wen/waddr/wdata outputs are 0, the FIFO is emptied (all entries invalid), and a_ready is 0 while rst is high. A reset mid-operation discards queued entries.
- All write-port outputs are registered. A result presented in cycle N is written to the file at edge N+1.
- Pipe mapping: master goes to port 1, slave goes to port 2. Pipe inputs have no backpressure and are never stalled.
- Address 0: any write to 0 is suppressed (wen stays 0). Async entries with address 0 are accepted and discarded without being stored.
- Master/slave same address, both valid: only the slave is written, on port 2. Port 1 is then considered free.
- Async handshake: a transfer occurs when a_valid && a_ready. a_ready = !full, computed from registered state only (no combinational path from inputs). An enqueue is not accepted while full, even if a dequeue happens in the same cycle.
- Dequeue: at most one entry per cycle, always the head.
  - Head goes to port 1 if port 1 is free (master not writing, or master suppressed by a collision).
  - Otherwise head goes to port 2 if slave is not valid.
  - Otherwise the head waits.
- Kill (WAW): every cycle, each valid FIFO entry whose address equals a pipe write address that is actually issued this cycle is invalidated. The pipe value is newer. An invalid head is popped without a write and does not consume a port.
- Simultaneous enqueue and pipe write to the same address: the incoming async entry is stored already killed.
- Entry order: FIFO order is preserved. The head pointer wraps modulo DEPTH. Count is in 0..DEPTH.
- Simultaneous enqueue and dequeue: count is unchanged.

Optional Feature:
WB_PENDING_MASK_EN
- Defined: adds output pending_mask (2^AW bits, combinational from registered state). Bit r = 1 while any valid, unkilled FIFO entry targets register r. Issue logic uses it to stall RAW hazards.
- Undefined: the port is absent and its logic is removed.

Test Plan:
1. Reset then m_valid=1, m_waddr=3, m_wdata=0x11, s_valid=1, s_waddr=4, s_wdata=0x22 -> next cycle wen1_a=1/addr 3/0x11 and wen2_a=1/addr 4/0x22. During the rst cycle all outputs are 0 and a_ready=0.
2. Master and slave both to reg 7 (0xAA, 0xBB), async head to reg 9 = 0xCC -> port 2 writes 7=0xBB, port 1 writes 9=0xCC, master write dropped.
3. Enqueue 4 async entries while both pipes write every cycle -> a_ready=0 after the 4th. When pipes go idle, the entries drain one per cycle in order on port 1. a_ready returns to 1 the cycle after the first pop.
4. Async entry reg 5 = 0x1 queued, then slave writes reg 5 = 0x2 -> the entry is killed, never written, and reg 5 ends at 0x2.
5. a_waddr=0 with pipes idle, and m_waddr=0 -> no write enable asserted and FIFO count unchanged.
6. With WB_PENDING_MASK_EN defined: enqueue reg 12 -> pending_mask bit 12 = 1. It clears the cycle after the entry is popped or killed.

Source files
------------

// File: rtl/reg_writeback.sv
// Register-file write front end: master/slave pipe results plus a queued async source onto two write ports.
// Optional feature macro: WB_PENDING_MASK_EN adds the pending_mask output.
module reg_writeback #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m_valid,
  input  logic [AW-1:0] m_waddr,
  input  logic [DW-1:0] m_wdata,
  input  logic          s_valid,
  input  logic [AW-1:0] s_waddr,
  input  logic [DW-1:0] s_wdata,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_waddr,
  input  logic [DW-1:0] a_wdata,
  output logic          wen1_a,
  output logic [AW-1:0] waddr1_a,
  output logic [DW-1:0] wdata1_a,
  output logic          wen2_a,
  output logic [AW-1:0] waddr2_a,
  output logic [DW-1:0] wdata2_a
`ifdef WB_PENDING_MASK_EN
  ,
  output logic [(1<<AW)-1:0] pending_mask
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0]    f_addr [DEPTH];
  logic [DW-1:0]    f_data [DEPTH];
  logic [DEPTH-1:0] f_vld, vld_next, kill;
  logic [PW-1:0]    head, tail;
  logic [CW-1:0]    count, count_next;
  logic             ready_q;

  logic m_issue, s_issue, collide;
  logic fifo_empty, head_live, pop, deq_p1, deq_p2, enq, enq_kill;

  assign a_ready = ready_q;

  always_comb begin
    collide    = m_valid && s_valid && (m_waddr == s_waddr);
    m_issue    = m_valid && (m_waddr != '0) && !collide;
    s_issue    = s_valid && (s_waddr != '0);
    kill       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      kill[i] = f_vld[i] && ((m_issue && f_addr[i] == m_waddr) ||
                             (s_issue && f_addr[i] == s_waddr));
    end
    fifo_empty = (count == '0);
    // A head invalidated by a newer pipe write is dropped without using a port
    head_live  = f_vld[head] && !kill[head];
    deq_p1     = !fifo_empty && head_live && !m_issue;
    deq_p2     = !fifo_empty && head_live && m_issue && !s_valid;
    pop        = !fifo_empty && (!head_live || deq_p1 || deq_p2);
    enq        = a_valid && ready_q && (a_waddr != '0);
    enq_kill   = (m_issue && a_waddr == m_waddr) || (s_issue && a_waddr == s_waddr);
    count_next = count + CW'(enq) - CW'(pop);
    vld_next   = f_vld & ~kill;
    if (pop) vld_next[head] = 1'b0;
    if (enq) vld_next[tail] = !enq_kill;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      f_vld    <= '0;
      ready_q  <= 1'b0;
      wen1_a   <= 1'b0;
      waddr1_a <= '0;
      wdata1_a <= '0;
      wen2_a   <= 1'b0;
      waddr2_a <= '0;
      wdata2_a <= '0;
    end else begin
      f_vld    <= vld_next;
      count    <= count_next;
      ready_q  <= (count_next != CW'(DEPTH));
      if (pop) head <= (head == PW'(DEPTH - 1)) ? '0 : head + 1'b1;
      if (enq) tail <= (tail == PW'(DEPTH - 1)) ? '0 : tail + 1'b1;

      wen1_a   <= m_issue || deq_p1;
      waddr1_a <= m_issue ? m_waddr : (deq_p1 ? f_addr[head] : '0);
      wdata1_a <= m_issue ? m_wdata : (deq_p1 ? f_data[head] : '0);
      wen2_a   <= s_issue || deq_p2;
      waddr2_a <= s_issue ? s_waddr : (deq_p2 ? f_addr[head] : '0);
      wdata2_a <= s_issue ? s_wdata : (deq_p2 ? f_data[head] : '0);
    end
  end

  // Payload storage needs no reset; validity lives in f_vld
  always_ff @(posedge clk) begin
    if (!rst && enq) begin
      f_addr[tail] <= a_waddr;
      f_data[tail] <= a_wdata;
    end
  end

`ifdef WB_PENDING_MASK_EN
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (f_vld[i]) pending_mask[f_addr[i]] = 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: per-cycle vector table through a scoreboard queue.
// Define WB_PENDING_MASK_EN to also exercise pending_mask.
module tb_reg_writeback;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          m_valid, s_valid, a_valid, a_ready;
  logic [AW-1:0] m_waddr, s_waddr, a_waddr, waddr1_a, waddr2_a;
  logic [DW-1:0] m_wdata, s_wdata, a_wdata, wdata1_a, wdata2_a;
  logic          wen1_a, wen2_a;
`ifdef WB_PENDING_MASK_EN
  logic [(1<<AW)-1:0] pending_mask;
`endif

  reg_writeback #(.DEPTH(4), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .m_valid(m_valid), .m_waddr(m_waddr), .m_wdata(m_wdata),
    .s_valid(s_valid), .s_waddr(s_waddr), .s_wdata(s_wdata),
    .a_valid(a_valid), .a_ready(a_ready), .a_waddr(a_waddr), .a_wdata(a_wdata),
    .wen1_a(wen1_a), .waddr1_a(waddr1_a), .wdata1_a(wdata1_a),
    .wen2_a(wen2_a), .waddr2_a(waddr2_a), .wdata2_a(wdata2_a)
`ifdef WB_PENDING_MASK_EN
    , .pending_mask(pending_mask)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          mv; logic [AW-1:0] ma; logic [DW-1:0] md;
    logic          sv; logic [AW-1:0] sa; logic [DW-1:0] sd;
    logic          av; logic [AW-1:0] aa; logic [DW-1:0] ad;
    logic          e1; logic [AW-1:0] ea1; logic [DW-1:0] ed1;
    logic          e2; logic [AW-1:0] ea2; logic [DW-1:0] ed2;
    logic          ear;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   checks = 0;
  int   failures = 0;

  function automatic vec_t mk(logic r,
      logic mv, int ma, int md, logic sv, int sa, int sd, logic av, int aa, int ad,
      logic e1, int ea1, int ed1, logic e2, int ea2, int ed2, logic ear);
    vec_t v;
    v.rst = r;
    v.mv = mv; v.ma = AW'(ma); v.md = DW'(md);
    v.sv = sv; v.sa = AW'(sa); v.sd = DW'(sd);
    v.av = av; v.aa = AW'(aa); v.ad = DW'(ad);
    v.e1 = e1; v.ea1 = AW'(ea1); v.ed1 = DW'(ed1);
    v.e2 = e2; v.ea2 = AW'(ea2); v.ed2 = DW'(ed2);
    v.ear = ear;
    return v;
  endfunction

  task automatic step(input vec_t v, input string name);
    vec_t  x;
    logic [2*(1+AW+DW):0] act, exp;
    rst = v.rst;
    m_valid = v.mv; m_waddr = v.ma; m_wdata = v.md;
    s_valid = v.sv; s_waddr = v.sa; s_wdata = v.sd;
    a_valid = v.av; a_waddr = v.aa; a_wdata = v.ad;
    sb.push_back(v);
    @(posedge clk);
    #1;
    x   = sb.pop_front();
    act = {wen1_a, waddr1_a, wdata1_a, wen2_a, waddr2_a, wdata2_a, a_ready};
    exp = {x.e1, x.ea1, x.ed1, x.e2, x.ea2, x.ed2, x.ear};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got w1=%b a1=%0d d1=%h w2=%b a2=%0d d2=%h rdy=%b, want w1=%b a1=%0d d1=%h w2=%b a2=%0d d2=%h rdy=%b",
               name, wen1_a, waddr1_a, wdata1_a, wen2_a, waddr2_a, wdata2_a, a_ready,
               x.e1, x.ea1, x.ed1, x.e2, x.ea2, x.ed2, x.ear);
    end
  endtask

`ifdef WB_PENDING_MASK_EN
  task automatic check_pm(input string name, input logic want);
    checks++;
    if (pending_mask[12] !== want) begin
      failures++;
      $display("FAIL %s: pending_mask[12]=%b want %b", name, pending_mask[12], want);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    //           rst mv ma  md    sv sa sd    av aa  ad     e1 ea1 ed1   e2 ea2 ed2  rdy
    tbl.push_back(mk(1, 0,0,0,    0,0,0,      0,0,0,        0,0,0,       0,0,0,      0));
    tbl.push_back(mk(1, 1,3,'h11, 1,4,'h22,   0,0,0,        0,0,0,       0,0,0,      0));
    tbl.push_back(mk(0, 1,3,'h11, 1,4,'h22,   0,0,0,        1,3,'h11,    1,4,'h22,   1));
    // collision on reg 7 lets the queued async result take port 1
    tbl.push_back(mk(0, 1,1,'h01, 1,2,'h02,   1,9,'hCC,     1,1,'h01,    1,2,'h02,   1));
    tbl.push_back(mk(0, 1,7,'hAA, 1,7,'hBB,   0,0,0,        1,9,'hCC,    1,7,'hBB,   1));
    // fill the FIFO under busy pipes, then drain in order
    tbl.push_back(mk(0, 1,1,'h10, 1,2,'h20,   1,10,'hA0,    1,1,'h10,    1,2,'h20,   1));
    tbl.push_back(mk(0, 1,1,'h11, 1,2,'h21,   1,11,'hB1,    1,1,'h11,    1,2,'h21,   1));
    tbl.push_back(mk(0, 1,1,'h12, 1,2,'h22,   1,12,'hC2,    1,1,'h12,    1,2,'h22,   1));
    tbl.push_back(mk(0, 1,1,'h13, 1,2,'h23,   1,13,'hD3,    1,1,'h13,    1,2,'h23,   0));
    tbl.push_back(mk(0, 1,1,'h14, 1,2,'h24,   1,14,'hE4,    1,1,'h14,    1,2,'h24,   0));
    tbl.push_back(mk(0, 0,0,0,    0,0,0,      0,0,0,        1,10,'hA0,   0,0,0,      1));
    tbl.push_back(mk(0, 0,0,0,    0,0,0,      0,0,0,        1,11,'hB1,   0,0,0,      1));
    tbl.push_back(mk(0, 0,0,0,    0,0,0,      0,0,0,        1,12,'hC2,   0,0,0,      1));
    tbl.push_back(mk(0, 0,0,0,    0,0,0,      0,0,0,        1,13,'hD3,   0,0,0,      1));
    tbl.push_back(mk(0, 0,0,0,    0,0,0,      0,0,0,        0,0,0,       0,0,0,      1));
    // queued reg 5 killed by newer slave write
    tbl.push_back(mk(0, 1,1,'h30, 1,2,'h31,   1,5,'h01,     1,1,'h30,    1,2,'h31,   1));
    tbl.push_back(mk(0, 1,6,'h40, 1,5,'h02,   0,0,0,        1,6,'h40,    1,5,'h02,   1));
    tbl.push_back(mk(0, 0,0,0,    0,0,0,      0,0,0,        0,0,0,       0,0,0,      1));
    // address 0 suppression on every source
    tbl.push_back(mk(0, 1,0,'h55, 0,0,0,      1,0,'h66,     0,0,0,       0,0,0,      1));
    tbl.push_back(mk(0, 0,0,0,    0,0,0,      0,0,0,        0,0,0,       0,0,0,      1));
    tbl.push_back(mk(0, 1,8,'h88, 1,0,'h77,   0,0,0,        1,8,'h88,    0,0,0,      1));
    // enqueue alongside a pipe write to the same reg: stored already dead
    tbl.push_back(mk(0, 1,20,'h91,0,0,0,      1,20,'h92,    1,20,'h91,   0,0,0,      1));
    tbl.push_back(mk(0, 0,0,0,    0,0,0,      0,0,0,        0,0,0,       0,0,0,      1));
    // head falls through to port 2 when master busy and slave idle
    tbl.push_back(mk(0, 1,1,'h50, 1,2,'h51,   1,21,'h61,    1,1,'h50,    1,2,'h51,   1));
    tbl.push_back(mk(0, 1,3,'h52, 0,0,0,      0,0,0,        1,3,'h52,    1,21,'h61,  1));
    // simultaneous enqueue and dequeue
    tbl.push_back(mk(0, 1,1,'h53, 1,2,'h54,   1,22,'h71,    1,1,'h53,    1,2,'h54,   1));
    tbl.push_back(mk(0, 0,0,0,    0,0,0,      1,23,'h72,    1,22,'h71,   0,0,0,      1));
    tbl.push_back(mk(0, 0,0,0,    0,0,0,      0,0,0,        1,23,'h72,   0,0,0,      1));
    tbl.push_back(mk(0, 0,0,0,    0,0,0,      0,0,0,        0,0,0,       0,0,0,      1));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

    // mid-operation reset discards the queued entry
    step(mk(0, 1,1,'h60, 1,2,'h61, 1,24,'h81, 1,1,'h60, 1,2,'h61, 1), "rst_mid_fill");
    step(mk(1, 0,0,0,    0,0,0,    0,0,0,     0,0,0,    0,0,0,    0), "rst_mid_assert");
    step(mk(0, 0,0,0,    0,0,0,    0,0,0,     0,0,0,    0,0,0,    1), "rst_mid_release");
    step(mk(0, 0,0,0,    0,0,0,    0,0,0,     0,0,0,    0,0,0,    1), "rst_mid_discard");

`ifdef WB_PENDING_MASK_EN
    step(mk(0, 1,1,'h1, 1,2,'h2, 1,12,'hC0, 1,1,'h1, 1,2,'h2, 1), "pm_enq_a");
    check_pm("pm_set_a", 1'b1);
    step(mk(0, 0,0,0,   0,0,0,   0,0,0,     1,12,'hC0, 0,0,0, 1), "pm_pop");
    check_pm("pm_clr_pop", 1'b0);
    step(mk(0, 1,1,'h3, 1,2,'h4, 1,12,'hC1, 1,1,'h3, 1,2,'h4, 1), "pm_enq_b");
    check_pm("pm_set_b", 1'b1);
    step(mk(0, 1,12,'h5, 1,2,'h6, 0,0,0,    1,12,'h5, 1,2,'h6, 1), "pm_kill");
    check_pm("pm_clr_kill", 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
